// File: rtl/bcd_to_unsigned_if.sv
// Handshake bundle between a requester and the BCD-to-binary converter.
// The converter attaches through the slave modport.
interface bcd_to_unsigned_if #(
  parameter int N_DIGITS  = 8,
  parameter int OUT_WIDTH = 32
);
  logic                    trigger;
  logic [4*N_DIGITS-1:0]   bcd;
  logic                    idle;
  logic                    done;
  logic [OUT_WIDTH-1:0]    out;
  logic                    error;
  logic                    overflow;

  modport master (output trigger, bcd, input idle, done, out, error, overflow);
  modport slave  (input trigger, bcd, output idle, done, out, error, overflow);
endinterface

// File: rtl/bcd_to_unsigned.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble):
// one bit per cycle is shifted out of the BCD word into the binary accumulator.
module bcd_to_unsigned #(
  parameter int N_DIGITS  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  bcd_to_unsigned_if.slave   bus
);
  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BCD_W + 1);
  localparam int EXT_W = (BCD_W > OUT_WIDTH) ? BCD_W : OUT_WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BCD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // After a right shift, a digit >= 8 received a borrowed 10 worth 8, so take 3 back.
  function automatic logic [BCD_W-1:0] dabble_fix(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd8) ? (v[4*i +: 4] - 4'd3) : v[4*i +: 4];
    end
    return r;
  endfunction

  state_t               state_r, state_s;
  logic [BCD_W-1:0]     bcd_r, bcd_s, acc_r, acc_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [OUT_WIDTH-1:0] out_r, out_s;
  logic                 error_r, error_s, overflow_r, overflow_s;
  logic                 idle_r, idle_s, done_r, done_s;
  logic [BCD_W-1:0]     shift_bcd_s, shift_acc_s;
  logic [EXT_W-1:0]     ext_s;
  logic                 bad_s;

  assign bad_s       = has_bad_digit(bus.bcd);
  assign shift_bcd_s = dabble_fix({1'b0, bcd_r[BCD_W-1:1]});
  assign shift_acc_s = {bcd_r[0], acc_r[BCD_W-1:1]};
  assign ext_s       = EXT_W'(shift_acc_s);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.trigger) begin
          state_s = bad_s ? ST_DONE : ST_CONVERT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (cnt_r == LAST_STEP) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CONVERT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath and result next-values.
  always_comb begin
    bcd_s      = bcd_r;
    acc_s      = acc_r;
    cnt_s      = cnt_r;
    out_s      = out_r;
    error_s    = error_r;
    overflow_s = overflow_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.trigger) begin
          bcd_s = bus.bcd;
          acc_s = '0;
          cnt_s = '0;
          if (bad_s) begin
            out_s      = '0;
            error_s    = 1'b1;
            overflow_s = 1'b0;
          end else begin
            out_s      = out_r;
            error_s    = error_r;
            overflow_s = overflow_r;
          end
        end else begin
          bcd_s = bcd_r;
          acc_s = acc_r;
          cnt_s = cnt_r;
        end
      end
      ST_CONVERT: begin
        bcd_s = shift_bcd_s;
        acc_s = shift_acc_s;
        cnt_s = cnt_r + CNT_W'(1);
        // Anything above OUT_WIDTH in the accumulator is lost to truncation.
        if (cnt_r == LAST_STEP) begin
          out_s      = ext_s[OUT_WIDTH-1:0];
          error_s    = 1'b0;
          overflow_s = |(ext_s >> OUT_WIDTH);
        end else begin
          out_s      = out_r;
          error_s    = error_r;
          overflow_s = overflow_r;
        end
      end
      ST_DONE: begin
        cnt_s = cnt_r;
      end
      default: begin
        cnt_s = '0;
      end
    endcase
    idle_s = (state_s == ST_IDLE);
    done_s = (state_s == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_r      <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      out_r      <= '0;
      error_r    <= 1'b0;
      overflow_r <= 1'b0;
      idle_r     <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      bcd_r      <= bcd_s;
      acc_r      <= acc_s;
      cnt_r      <= cnt_s;
      out_r      <= out_s;
      error_r    <= error_s;
      overflow_r <= overflow_s;
      idle_r     <= idle_s;
      done_r     <= done_s;
    end
  end

  assign bus.idle     = idle_r;
  assign bus.done     = done_r;
  assign bus.out      = out_r;
  assign bus.error    = error_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Bench for bcd_to_unsigned: a 32-bit and a 16-bit result instance run the same
// stimulus and are checked against a decimal reference model.
module tb_bcd_to_unsigned;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bcd_to_unsigned_if #(.N_DIGITS(8), .OUT_WIDTH(32)) bus32 ();
  bcd_to_unsigned_if #(.N_DIGITS(8), .OUT_WIDTH(16)) bus16 ();

  bcd_to_unsigned #(.N_DIGITS(8), .OUT_WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  bcd_to_unsigned #(.N_DIGITS(8), .OUT_WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Decimal value of the digits, then reduced to the output width.
  function automatic void ref_model(input logic [31:0] b, input int w,
                                    output logic [63:0] v, output logic err, output logic ovf);
    logic [63:0] num;
    logic [3:0]  d;
    num = 64'd0;
    err = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) err = 1'b1;
      num = num * 64'd10 + 64'(d);
    end
    if (err) begin
      v   = 64'd0;
      ovf = 1'b0;
    end else begin
      ovf = (num >> w) != 64'd0;
      v   = num & ((64'd1 << w) - 64'd1);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic trig, input logic [31:0] b);
    bus32.trigger = trig;
    bus32.bcd     = b;
    bus16.trigger = trig;
    bus16.bcd     = b;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!bus32.idle && n < 100) begin
      tick();
      n++;
    end
    check({tag, ":idle_wait"}, 64'(bus32.idle), 64'd1);
  endtask

  task automatic convert(input logic [31:0] b, input string tag);
    logic [63:0] e32, e16;
    logic        er, o32, o16;
    int          n;
    ref_model(b, 32, e32, er, o32);
    ref_model(b, 16, e16, er, o16);
    wait_idle(tag);
    drive(1'b1, b);
    tick();
    drive(1'b0, 32'h0);
    check({tag, ":idle_drop"}, 64'(bus32.idle), 64'd0);
    n = 0;
    while (!bus32.done && n < 100) begin
      tick();
      n++;
    end
    check({tag, ":latency"}, 64'(n), er ? 64'd0 : 64'd32);
    check({tag, ":out32"}, 64'(bus32.out), e32);
    check({tag, ":err32"}, 64'(bus32.error), 64'(er));
    check({tag, ":ovf32"}, 64'(bus32.overflow), 64'(o32));
    check({tag, ":done16"}, 64'(bus16.done), 64'd1);
    check({tag, ":out16"}, 64'(bus16.out), e16);
    check({tag, ":ovf16"}, 64'(bus16.overflow), 64'(o16));
    tick();
    check({tag, ":done_one"}, 64'(bus32.done), 64'd0);
    check({tag, ":idle_back"}, 64'(bus32.idle), 64'd1);
  endtask

  initial begin
    logic [31:0] b;
    logic [63:0] e;
    logic        er, ov;
    int          n, pos, last;
    int          done_at[$];

    reset = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    tick();
    check("rst:idle", 64'(bus32.idle), 64'd1);
    check("rst:done", 64'(bus32.done), 64'd0);
    check("rst:out", 64'(bus32.out), 64'd0);
    check("rst:err", 64'(bus32.error), 64'd0);
    check("rst:ovf", 64'(bus32.overflow), 64'd0);
    reset = 1'b0;
    tick();

    convert(32'h12345678, "d12345678");
    check("k12345678", 64'(bus32.out), 64'h00BC614E);
    convert(32'h99999999, "d99999999");
    check("k99999999", 64'(bus32.out), 64'h05F5E0FF);
    convert(32'h00000000, "dzero");
    convert(32'hFF123456, "dblank");
    check("kblank_err", 64'(bus32.error), 64'd1);
    convert(32'h00000001, "dclear");
    check("kclear_err", 64'(bus32.error), 64'd0);
    convert(32'h00065536, "d65536");
    check("k65536_16", 64'(bus16.out), 64'h0);
    check("k65536_ov", 64'(bus16.overflow), 64'd1);
    convert(32'h00065535, "d65535");
    check("k65535_16", 64'(bus16.out), 64'hFFFF);
    check("k65535_ov", 64'(bus16.overflow), 64'd0);

    // Trigger held during conversion with a different value must be ignored.
    wait_idle("hold");
    drive(1'b1, 32'h00000042);
    tick();
    drive(1'b1, 32'h00000999);
    n = 0;
    while (!bus32.done && n < 100) begin
      tick();
      n++;
    end
    check("hold:latency", 64'(n), 64'd32);
    check("hold:out", 64'(bus32.out), 64'd42);
    drive(1'b0, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus32.done) n++;
    end
    check("hold:no_extra_done", 64'(n), 64'd0);

    // Continuous trigger: one done every 34 cycles.
    wait_idle("b2b");
    drive(1'b1, 32'h00482913);
    ref_model(32'h00482913, 32, e, er, ov);
    for (int i = 0; i < 120; i++) begin
      tick();
      if (bus32.done) begin
        done_at.push_back(i);
        check("b2b:out", 64'(bus32.out), e);
      end
    end
    drive(1'b0, 32'h0);
    check("b2b:count", 64'(done_at.size()), 64'd3);
    last = -1;
    foreach (done_at[k]) begin
      if (k > 0) check("b2b:period", 64'(done_at[k] - last), 64'd34);
      last = done_at[k];
    end

    // Reset in the middle of a conversion aborts it.
    convert(32'h12345678, "pre_rst");
    wait_idle("abort");
    drive(1'b1, 32'h00000042);
    tick();
    drive(1'b0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    check("abort:idle", 64'(bus32.idle), 64'd1);
    check("abort:done", 64'(bus32.done), 64'd0);
    check("abort:out", 64'(bus32.out), 64'd0);
    check("abort:out16", 64'(bus16.out), 64'd0);
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus32.done) n++;
    end
    check("abort:no_done", 64'(n), 64'd0);
    convert(32'h00000007, "d7");
    check("k7", 64'(bus32.out), 64'd7);

    // Random digits, occasionally with a non-decimal nibble.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
        pos = $urandom_range(0, 7);
        b[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      convert(b, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
